// File: rtl/mac_pkg.sv
// Shared definitions for the MAC datapath: accumulator result width and
// the depth of the result drain FIFO.
package mac_pkg;

   localparam int MAC_DATA_W      = 9;
   localparam int MAC_DRAIN_DEPTH = 4;

   typedef logic [MAC_DATA_W-1:0] mac_data_t;

endpackage

// File: rtl/mac_drain_mem.sv
// Register-array storage for the result drain: one synchronous write port
// and one asynchronous read port, so the FIFO head falls through combinationally.
module mac_drain_mem #(
   parameter int DATA_W = 9,
   parameter int DEPTH  = 4,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Contents are deliberately not reset; the drain's count masks stale entries.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/mac_result_drain.sv
// Captures strobed accumulator results into a small FWFT FIFO and hands them
// to a valid/ready sink; results arriving while full are dropped and flagged.
module mac_result_drain
   import mac_pkg::*;
#(
   parameter int DATA_W = MAC_DATA_W,
   parameter int DEPTH  = MAC_DRAIN_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       acc_valid,
   input  logic [DATA_W-1:0]          acc_data,
   output logic                       out_valid,
   output logic [DATA_W-1:0]          out_data,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow,
   input  logic                       ovf_clr
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [DATA_W-1:0] head_data;
   logic              full;
   logic              pop;
   logic              push;
   logic              drop;

   // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
   always_comb begin
      full      = (count == FULL_CNT);
      out_valid = (count != '0);
      pop       = out_valid & out_ready;
      push      = acc_valid & (~full | pop);
      drop      = acc_valid & full & ~pop;
      out_data  = out_valid ? head_data : '0;
   end

   mac_drain_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (PTR_W)
   ) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr),
      .wdata (acc_data),
      .raddr (rd_ptr),
      .rdata (head_data)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // A drop in the same cycle as a clear must leave the flag set.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end else if (ovf_clr) begin
         overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mac_result_drain.sv
// Self-checking bench for mac_result_drain: queue-based reference model plus
// a table of fill/drop/drain vectors and hand-written corner-case sequences.
module tb_mac_result_drain;
   import mac_pkg::*;

   localparam int DEPTH = MAC_DRAIN_DEPTH;
   localparam int CNT_W = $clog2(DEPTH+1);

   logic                  clk;
   logic                  rst;
   logic                  acc_valid;
   logic [MAC_DATA_W-1:0] acc_data;
   logic                  out_valid;
   logic [MAC_DATA_W-1:0] out_data;
   logic                  out_ready;
   logic [CNT_W-1:0]      count;
   logic                  overflow;
   logic                  ovf_clr;

   int        checks = 0;
   int        errors = 0;
   mac_data_t sb[$];
   logic      model_ovf = 1'b0;
   mac_data_t last_pop = '0;

   typedef struct {
      logic      v;
      mac_data_t d;
      logic      rdy;
      logic      clr;
      int        exp_count;
      logic      exp_ovf;
   } vec_t;

   vec_t vecs[10];

   mac_result_drain #(
      .DATA_W (MAC_DATA_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .acc_valid (acc_valid),
      .acc_data  (acc_data),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .count     (count),
      .overflow  (overflow),
      .ovf_clr   (ovf_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs at the falling edge, check the current state
   // against the model, then advance the model to match the coming rising edge.
   task automatic applyStimulus(input logic v, input mac_data_t d, input logic rdy, input logic clr);
      int        sz;
      logic      m_pop;
      logic      m_full;
      mac_data_t exp;
      @(negedge clk);
      acc_valid = v;
      acc_data  = d;
      out_ready = rdy;
      ovf_clr   = clr;
      #1;
      sz = sb.size();
      checkOutput("out_valid", 32'(out_valid), 32'(sz != 0));
      checkOutput("count", 32'(count), 32'(sz));
      checkOutput("overflow", 32'(overflow), 32'(model_ovf));
      if (sz == 0) checkOutput("out_data_empty", 32'(out_data), 32'd0);
      m_pop  = (sz != 0) && rdy;
      m_full = (sz == DEPTH);
      if (m_pop) begin
         exp = sb.pop_front();
         checkOutput("out_data", 32'(out_data), 32'(exp));
         last_pop = exp;
      end
      if (v && (!m_full || m_pop)) sb.push_back(d);
      if (v && m_full && !m_pop) model_ovf = 1'b1;
      else if (clr) model_ovf = 1'b0;
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
   endtask

   initial begin
      rst       = 1'b0;
      acc_valid = 1'b0;
      acc_data  = '0;
      out_ready = 1'b0;
      ovf_clr   = 1'b0;

      vecs[0] = '{1'b1, 9'h001, 1'b0, 1'b0, 1, 1'b0};
      vecs[1] = '{1'b1, 9'h002, 1'b0, 1'b0, 2, 1'b0};
      vecs[2] = '{1'b1, 9'h003, 1'b0, 1'b0, 3, 1'b0};
      vecs[3] = '{1'b1, 9'h004, 1'b0, 1'b0, 4, 1'b0};
      vecs[4] = '{1'b1, 9'h1FF, 1'b0, 1'b0, 4, 1'b1};
      vecs[5] = '{1'b0, 9'h000, 1'b1, 1'b0, 3, 1'b1};
      vecs[6] = '{1'b0, 9'h000, 1'b1, 1'b0, 2, 1'b1};
      vecs[7] = '{1'b0, 9'h000, 1'b1, 1'b0, 1, 1'b1};
      vecs[8] = '{1'b0, 9'h000, 1'b1, 1'b0, 0, 1'b1};
      vecs[9] = '{1'b0, 9'h000, 1'b1, 1'b0, 0, 1'b1};

      repeat (3) @(negedge clk);
      #1;
      checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_out_data", 32'(out_data), 32'd0);
      checkOutput("reset_count", 32'(count), 32'd0);
      checkOutput("reset_overflow", 32'(overflow), 32'd0);
      rst = 1'b1;

      $display("[TB] single push latency");
      applyStimulus(1'b1, 9'h0A5, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      checkOutput("first_valid", 32'(out_valid), 32'd1);
      checkOutput("first_data", 32'(out_data), 32'h0A5);
      checkOutput("first_count", 32'(count), 32'd1);
      drain(2);

      $display("[TB] table: fill, drop, drain");
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].v, vecs[i].d, vecs[i].rdy, vecs[i].clr);
         @(posedge clk);
         #1;
         checkOutput($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
         checkOutput($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].exp_ovf));
      end
      checkOutput("table_last_pop", 32'(last_pop), 32'h004);
      applyStimulus(1'b0, '0, 1'b0, 1'b1);

      $display("[TB] push while full with pop");
      for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, mac_data_t'(9'h010 + i), 1'b0, 1'b0);
      applyStimulus(1'b1, 9'h055, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("full_pop_count", 32'(count), 32'(DEPTH));
      checkOutput("full_pop_ovf", 32'(overflow), 32'd0);
      drain(DEPTH + 1);
      checkOutput("full_pop_last", 32'(last_pop), 32'h055);

      $display("[TB] overflow set beats clear");
      for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1'b1, mac_data_t'(9'h020 + i), 1'b0, 1'b0);
      applyStimulus(1'b1, 9'h0AA, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      checkOutput("set_wins_ovf", 32'(overflow), 32'd1);
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      checkOutput("clear_ovf", 32'(overflow), 32'd0);
      drain(DEPTH + 1);

      $display("[TB] back-to-back stream");
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, mac_data_t'(9'h100 + i * 7), 1'b1, 1'b0);
         if (count > CNT_W'(1)) checkOutput("stream_count_le1", 32'(count), 32'd1);
      end
      drain(2);
      checkOutput("stream_last", 32'(last_pop), 32'h100 + 32'd63);

      $display("[TB] asynchronous reset mid-burst");
      for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1'b1, mac_data_t'(9'h030 + i), 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      @(posedge clk);
      #3;
      acc_valid = 1'b0;
      out_ready = 1'b0;
      ovf_clr   = 1'b0;
      checkOutput("pre_reset_count", 32'(count), 32'd3);
      rst = 1'b0;
      #1;
      checkOutput("async_out_valid", 32'(out_valid), 32'd0);
      checkOutput("async_out_data", 32'(out_data), 32'd0);
      checkOutput("async_count", 32'(count), 32'd0);
      checkOutput("async_overflow", 32'(overflow), 32'd0);
      sb.delete();
      model_ovf = 1'b0;
      repeat (2) @(negedge clk);
      #2;
      rst = 1'b1;
      applyStimulus(1'b1, 9'h123, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkOutput("post_reset_first", 32'(last_pop), 32'h123);
      applyStimulus(1'b0, '0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
